// File: rtl/adc_pkg.sv
// ============================================================================
// Module      : adc_pkg
// Description : Constants and types shared by the SAR search controller and
//               the analog-side DAC responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    // Code width shared with the search controller
    localparam int ADC_WIDTH    = 8;

    // Width of the settle-period counter (SETTLE_PERIODS is 1..255)
    localparam int SETTLE_CNT_W = 8;

    // Responder sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Two-out-of-three vote
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/comp_sync.sv
// ============================================================================
// Module      : comp_sync
// Description : Multi-stage flip-flop synchronizer that brings the external
//               asynchronous comparator output into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sar_dac_responder.sv
// ============================================================================
// Module      : sar_dac_responder
// Description : Analog-side responder for the SAR search controller. Drives
//               the trial code as a PWM DAC, waits a fixed number of PWM
//               periods for the RC filter to settle, then samples the
//               synchronized comparator and returns a one-cycle result.
//               Optional build macro COMP_MAJORITY_EN: sample the comparator
//               on three consecutive cycles and report the majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_dac_responder
    import adc_pkg::*;
#(
    parameter int WIDTH          = ADC_WIDTH,
    parameter int SETTLE_PERIODS = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trial_valid,
    output logic             trial_ready,
    input  logic [WIDTH-1:0] code,
    output logic             result_valid,
    output logic             compares,
    input  logic             comp_in,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0]        c_PWM_MAX    = '1;
    localparam logic [SETTLE_CNT_W-1:0] c_SETTLE_TGT = SETTLE_CNT_W'(SETTLE_PERIODS);

    state_t                  r_state;
    logic [WIDTH-1:0]        r_pwm_cnt;
    logic [WIDTH-1:0]        r_active_code;
    logic [WIDTH-1:0]        r_pending_code;
    logic [SETTLE_CNT_W-1:0] r_settle_cnt;
    logic                    r_result_valid;
    logic                    r_compares;
    logic                    r_pwm_out;

    logic                    w_comp_sync;
    logic                    w_wrap;
    logic [SETTLE_CNT_W-1:0] w_settle_next;

`ifdef COMP_MAJORITY_EN
    logic [1:0]              r_samp_cnt;
    logic [1:0]              r_samp;
`endif

    comp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (comp_in),
        .o_sync  (w_comp_sync)
    );

    // The PWM period boundary is the only point where the DAC level may change
    assign w_wrap        = (r_pwm_cnt == c_PWM_MAX);
    assign w_settle_next = r_settle_cnt + 1'b1;

    // Free-running PWM counter and registered compare output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_pwm_out <= (r_pwm_cnt < r_active_code);
        end
    end

    // Trial sequencing: accept, load at wrap, settle, sample, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_active_code  <= '0;
            r_pending_code <= '0;
            r_settle_cnt   <= '0;
            r_result_valid <= 1'b0;
            r_compares     <= 1'b0;
`ifdef COMP_MAJORITY_EN
            r_samp_cnt     <= 2'd0;
            r_samp         <= 2'b00;
`endif
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trial_valid) begin
                        r_pending_code <= code;
                        r_settle_cnt   <= '0;
                        r_state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_wrap) begin
                        r_active_code <= r_pending_code;
                        r_state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_wrap) begin
                        r_settle_cnt <= w_settle_next;
                        if (w_settle_next == c_SETTLE_TGT) begin
                            r_state <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
`ifdef COMP_MAJORITY_EN
                    if (r_samp_cnt == 2'd2) begin
                        r_compares     <= maj3({r_samp, w_comp_sync});
                        r_samp_cnt     <= 2'd0;
                        r_result_valid <= 1'b1;
                        r_state        <= RESP;
                    end else begin
                        r_samp     <= {r_samp[0], w_comp_sync};
                        r_samp_cnt <= r_samp_cnt + 2'd1;
                    end
`else
                    r_compares     <= w_comp_sync;
                    r_result_valid <= 1'b1;
                    r_state        <= RESP;
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign trial_ready  = (r_state == IDLE);
    assign result_valid = r_result_valid;
    assign compares     = r_compares;
    assign pwm_out      = r_pwm_out;

endmodule

`default_nettype wire

// File: tb/tb_sar_dac_responder.sv
// ============================================================================
// Module      : tb_sar_dac_responder
// Description : Self-checking bench for sar_dac_responder (WIDTH=8,
//               SETTLE_PERIODS=2). Honours COMP_MAJORITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sar_dac_responder;

    localparam int W  = 8;
    localparam int SP = 2;
    localparam int NS = 2;
`ifdef COMP_MAJORITY_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    // Cycles from a pwm_cnt==0 accept cycle to the result strobe
    localparam int LAT = (1 << W) * (SP + 1) + 1 + EXTRA;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         trial_valid = 1'b0;
    logic [W-1:0] code = '0;
    logic         comp_in = 1'b0;
    logic         trial_ready;
    logic         result_valid;
    logic         compares;
    logic         pwm_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] code;
        logic       comp;
        logic       busy;
        int         exp_duty;
        logic       exp_cmp;
    } vec_t;

    vec_t vecs[5];

    sar_dac_responder #(
        .WIDTH          (W),
        .SETTLE_PERIODS (SP),
        .SYNC_STAGES    (NS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trial_valid  (trial_valid),
        .trial_ready  (trial_ready),
        .code         (code),
        .result_valid (result_valid),
        .compares     (compares),
        .comp_in      (comp_in),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    // Reference model of the free-running PWM counter
    logic [W-1:0] m_cnt;
    always @(posedge clk) begin
        if (rst) m_cnt <= '0;
        else     m_cnt <= m_cnt + 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt0();
        int n;
        n = 0;
        while (m_cnt != 0 && n < 300) begin
            tick();
            n++;
        end
        check("align_timeout", (m_cnt == 0) ? 1 : 0, 1);
    endtask

    // Accept a trial in a pwm_cnt==0 cycle and observe the whole transaction
    task automatic run_trial(input vec_t v, output int duty, output int lat,
                             output int pulses, output int cmp, output int rdy_bad);
        int k;
        duty = 0; lat = -1; pulses = 0; cmp = -1; rdy_bad = 0;
        comp_in = v.comp;
        wait_cnt0();
        code        = v.code;
        trial_valid = 1'b1;
        for (k = 1; k <= LAT + 20; k++) begin
            tick();
            trial_valid = 1'b0;
            if (v.busy && k >= 300 && k <= 303) begin
                trial_valid = 1'b1;
                code        = 8'h10;
            end
            // One-cycle comparator glitch lands on the middle majority sample
            if (k == LAT - 4) comp_in = ~v.comp;
            if (k == LAT - 3) comp_in = v.comp;
            if (k >= 510 && k <= 765 && pwm_out) duty++;
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    cmp = compares;
                end
            end
            if (trial_ready != (k > LAT)) rdy_bad++;
        end
        trial_valid = 1'b0;
    endtask

    initial begin
        int duty, lat, pulses, cmp, rdy_bad, bad, n;
        logic [7:0] res, trial;
        int diff;

        vecs[0] = '{8'h00, 1'b0, 1'b0,   0, 1'b0};
        vecs[1] = '{8'h80, 1'b1, 1'b0, 128, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 255, 1'b1};
        vecs[3] = '{8'h80, 1'b0, 1'b1, 128, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b0,   1, 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready",  trial_ready,  1);
        check("rst_rvalid", result_valid, 0);
        check("rst_cmp",    compares,     0);
        check("rst_pwm",    pwm_out,      0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pwm_out || result_valid || compares || !trial_ready) bad++;
        end
        check("idle_300_quiet", bad, 0);

        // Table-driven trials: duty, latency, strobe width, decision, ready
        for (int i = 0; i < 5; i++) begin
            run_trial(vecs[i], duty, lat, pulses, cmp, rdy_bad);
            check($sformatf("v%0d_duty", i),    duty,    vecs[i].exp_duty);
            check($sformatf("v%0d_latency", i), lat,     LAT);
            check($sformatf("v%0d_pulses", i),  pulses,  1);
            check($sformatf("v%0d_compares", i), cmp,    int'(vecs[i].exp_cmp));
            check($sformatf("v%0d_ready", i),   rdy_bad, 0);
            if (vecs[i].busy) begin
                bad = 0;
                for (int j = 0; j < 600; j++) begin
                    tick();
                    if (result_valid || !trial_ready) bad++;
                end
                check("busy_no_second_trial", bad, 0);
            end
        end

        // Reset in the middle of SETTLE discards the trial
        comp_in = 1'b1;
        wait_cnt0();
        code        = 8'hC0;
        trial_valid = 1'b1;
        tick();
        trial_valid = 1'b0;
        repeat (399) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready",   trial_ready,  1);
        check("midrst_pwm",     pwm_out,      0);
        check("midrst_rvalid",  result_valid, 0);
        check("midrst_cmp",     compares,     0);
        bad = 0;
        for (int j = 0; j < 1100; j++) begin
            tick();
            if (result_valid || pwm_out || !trial_ready) bad++;
        end
        check("midrst_quiet", bad, 0);

        // Closed-loop binary search against a comparator model, vin = 0x5A
        res = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            trial       = res | (8'h01 << b);
            comp_in     = (8'h5A > trial);
            code        = trial;
            trial_valid = 1'b1;
            tick();
            trial_valid = 1'b0;
            n = 0;
            while (!result_valid && n < LAT + 300) begin
                tick();
                n++;
            end
            if (!result_valid) begin
                check("loop_timeout", 0, 1);
                break;
            end
            if (compares) res = res | (8'h01 << b);
            tick();
        end
        diff = (res > 8'h5A) ? int'(res) - 8'h5A : 8'h5A - int'(res);
        check("loop_within_1", (diff <= 1) ? 1 : 0, 1);
        check("loop_final",    res, 8'h59);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
